// File: rtl/addr_unit_pkg.sv
// Shared definitions for the addressing unit with return-address stack.
//   - MODE_* : 3-bit addressing-mode encoding driven by the controller.
//   - ext()  : extends an immediate of imm_w bits to 64 bits, sign- or
//              zero-filled. Callers truncate the result to their address width.
package addr_unit_pkg;

    localparam logic [2:0] MODE_PC1    = 3'd0;  // pc + 1
    localparam logic [2:0] MODE_PCI    = 3'd1;  // pc + ext(imm)
    localparam logic [2:0] MODE_I0     = 3'd2;  // zero-extended imm, absolute
    localparam logic [2:0] MODE_R0     = 3'd3;  // register operand
    localparam logic [2:0] MODE_CALLI  = 3'd4;  // pc-relative call
    localparam logic [2:0] MODE_CALLR  = 3'd5;  // register call
    localparam logic [2:0] MODE_RET    = 3'd6;  // return to top of stack
    localparam logic [2:0] MODE_RST_PC = 3'd7;  // soft reset of pc and stack

    // Shift the immediate up to the top of a 64-bit word, then shift it back
    // down arithmetically (sign fill) or logically (zero fill). Using shifts
    // instead of bit indexing keeps this independent of the immediate width.
    function automatic logic [63:0] ext(input logic [63:0] imm,
                                        input int unsigned imm_w,
                                        input logic sgn);
        logic [63:0] top_aligned;
        int unsigned sh;
        sh          = 64 - imm_w;
        top_aligned = imm << sh;
        if (sgn)
            return $unsigned($signed(top_aligned) >>> sh);
        else
            return top_aligned >> sh;
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// LIFO return-address stack built from a register array and a count pointer.
//   clk, rst  : clock and synchronous active-high reset (count cleared)
//   clr       : synchronous clear of the count (contents retained)
//   push      : write data_in at the current top; ignored when full
//   pop       : discard the top entry; ignored when empty
//   data_in   : value to push
//   top       : combinational view of the newest entry (undefined when empty)
//   count     : number of valid entries, 0..DEPTH
//   full/empty: count == DEPTH / count == 0
// push and pop are never asserted together by the parent.
module ret_addr_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               data_in,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] count_reg;
    logic [PTR_W-1:0] count_dec;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == DEPTH_C);
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign count_dec = count_reg - PTR_W'(1);
    // DEPTH is a power of two, so the low bits of the count address the slot.
    assign wr_idx    = count_reg[IDX_W-1:0];
    assign rd_idx    = count_dec[IDX_W-1:0];
    assign top       = mem[rd_idx];

    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    // Storage is deliberately not reset; only the count defines validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[wr_idx] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            count_reg <= '0;
        else if (do_push)
            count_reg <= count_reg + PTR_W'(1);
        else if (do_pop)
            count_reg <= count_dec;
    end

endmodule

// File: rtl/addressing_unit_rs.sv
// Program/data addressing unit with a hardware return-address stack.
//   clk, rst    : clock and synchronous active-high reset
//   r_side      : register operand
//   i_side      : immediate operand
//   mode        : addressing mode (MODE_* in addr_unit_pkg)
//   pc_en       : commit the current mode on this clock edge
//   err_clr     : clear the sticky error flags
//   address     : combinational address for the current mode and operands
//   pc          : program counter register
//   sp_count    : number of valid return-stack entries
//   stack_full  : sp_count == STACK_DEPTH
//   stack_empty : sp_count == 0
//   err_ovf     : sticky, a CALL was committed while the stack was full
//   err_unf     : sticky, a RET was committed while the stack was empty
module addressing_unit_rs
    import addr_unit_pkg::*;
#(
    parameter int              ADDR_W      = 16,
    parameter int              IMM_W       = 8,
    parameter bit              IMM_SIGNED  = 1'b1,
    parameter int              STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             r_side,
    input  logic [IMM_W-1:0]              i_side,
    input  logic [2:0]                    mode,
    input  logic                          pc_en,
    input  logic                          err_clr,
    output logic [ADDR_W-1:0]             address,
    output logic [ADDR_W-1:0]             pc,
    output logic [$clog2(STACK_DEPTH):0]  sp_count,
    output logic                          stack_full,
    output logic                          stack_empty,
    output logic                          err_ovf,
    output logic                          err_unf
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] imm_zext;
    logic [63:0]       imm_ext_full;
    logic [ADDR_W-1:0] stack_top;
    logic [ADDR_W-1:0] address_next;
    logic              push_req;
    logic              pop_req;
    logic              clr_req;
    logic              ovf_set;
    logic              unf_set;
    logic              err_ovf_reg;
    logic              err_unf_reg;
    logic              full_w;
    logic              empty_w;

    assign imm_ext_full = ext(64'(i_side), IMM_W, IMM_SIGNED);
    assign imm_ext      = imm_ext_full[ADDR_W-1:0];
    assign imm_zext     = ADDR_W'(i_side);
    assign pc_plus1     = pc_reg + ADDR_W'(1);

    // Address mux plus stack control. A CALL on a full stack or a RET on an
    // empty stack presents the current pc, so committing it leaves pc unchanged.
    always_comb begin
        address_next = pc_plus1;
        push_req     = 1'b0;
        pop_req      = 1'b0;
        clr_req      = 1'b0;
        ovf_set      = 1'b0;
        unf_set      = 1'b0;
        case (mode)
            MODE_PC1:   address_next = pc_plus1;
            MODE_PCI:   address_next = pc_reg + imm_ext;
            MODE_I0:    address_next = imm_zext;
            MODE_R0:    address_next = r_side;
            MODE_CALLI, MODE_CALLR: begin
                if (full_w) begin
                    address_next = pc_reg;
                    ovf_set      = pc_en;
                end else begin
                    address_next = (mode == MODE_CALLI) ? pc_reg + imm_ext : r_side;
                    push_req     = pc_en;
                end
            end
            MODE_RET: begin
                if (empty_w) begin
                    address_next = pc_reg;
                    unf_set      = pc_en;
                end else begin
                    address_next = stack_top;
                    pop_req      = pc_en;
                end
            end
            MODE_RST_PC: begin
                address_next = RESET_VEC;
                clr_req      = pc_en;
            end
            default:    address_next = pc_plus1;
        endcase
    end

    ret_addr_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_req),
        .push    (push_req),
        .pop     (pop_req),
        .data_in (pc_plus1),
        .top     (stack_top),
        .count   (sp_count),
        .full    (full_w),
        .empty   (empty_w)
    );

    always_ff @(posedge clk) begin
        if (rst)
            pc_reg <= RESET_VEC;
        else if (pc_en)
            pc_reg <= address_next;
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            if (ovf_set)
                err_ovf_reg <= 1'b1;
            else if (err_clr)
                err_ovf_reg <= 1'b0;
            if (unf_set)
                err_unf_reg <= 1'b1;
            else if (err_clr)
                err_unf_reg <= 1'b0;
        end
    end

    assign address     = address_next;
    assign pc          = pc_reg;
    assign stack_full  = full_w;
    assign stack_empty = empty_w;
    assign err_ovf     = err_ovf_reg;
    assign err_unf     = err_unf_reg;

endmodule

// File: tb/tb_addressing_unit_rs.sv
// Directed scoreboard bench for addressing_unit_rs. Stimulus pushes expected
// values into a queue and raises chk_valid; a monitor on the falling edge pops
// and compares every queued expectation against the DUT outputs.
module tb_addressing_unit_rs;
    import addr_unit_pkg::*;

    localparam int ADDR_W = 16;
    localparam int IMM_W  = 8;
    localparam int DEPTH  = 8;

    // Signal selectors for the scoreboard
    localparam int K_PC    = 0;
    localparam int K_ADDR  = 1;
    localparam int K_SP    = 2;
    localparam int K_OVF   = 3;
    localparam int K_UNF   = 4;
    localparam int K_EMPTY = 5;
    localparam int K_FULL  = 6;
    localparam int K_ADDRU = 7;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] r_side = '0;
    logic [IMM_W-1:0]  i_side = '0;
    logic [2:0]        mode = MODE_PC1;
    logic              pc_en = 1'b0;
    logic              err_clr = 1'b0;

    logic [ADDR_W-1:0] address, pc;
    logic [3:0]        sp_count;
    logic              stack_full, stack_empty, err_ovf, err_unf;

    logic [ADDR_W-1:0] address_u, pc_u;
    logic [3:0]        sp_count_u;
    logic              stack_full_u, stack_empty_u, err_ovf_u, err_unf_u;

    exp_t exp_q[$];
    logic chk_valid = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    addressing_unit_rs #(
        .ADDR_W(ADDR_W), .IMM_W(IMM_W), .IMM_SIGNED(1'b1),
        .STACK_DEPTH(DEPTH), .RESET_VEC(16'h0100)
    ) dut (
        .clk(clk), .rst(rst), .r_side(r_side), .i_side(i_side), .mode(mode),
        .pc_en(pc_en), .err_clr(err_clr), .address(address), .pc(pc),
        .sp_count(sp_count), .stack_full(stack_full), .stack_empty(stack_empty),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    addressing_unit_rs #(
        .ADDR_W(ADDR_W), .IMM_W(IMM_W), .IMM_SIGNED(1'b0),
        .STACK_DEPTH(DEPTH), .RESET_VEC(16'h0100)
    ) dut_u (
        .clk(clk), .rst(rst), .r_side(r_side), .i_side(i_side), .mode(mode),
        .pc_en(pc_en), .err_clr(err_clr), .address(address_u), .pc(pc_u),
        .sp_count(sp_count_u), .stack_full(stack_full_u), .stack_empty(stack_empty_u),
        .err_ovf(err_ovf_u), .err_unf(err_unf_u)
    );

    // Monitor: drains the scoreboard whenever the stimulus flags a check point.
    always @(negedge clk) begin
        if (chk_valid) begin
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [15:0] act;
                e = exp_q.pop_front();
                case (e.kind)
                    K_PC:    act = pc;
                    K_ADDR:  act = address;
                    K_SP:    act = 16'(sp_count);
                    K_OVF:   act = 16'(err_ovf);
                    K_UNF:   act = 16'(err_unf);
                    K_EMPTY: act = 16'(stack_empty);
                    K_FULL:  act = 16'(stack_full);
                    default: act = address_u;
                endcase
                n_assert++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.exp);
                end else begin
                    $display("ok   %s = 0x%04h", e.name, act);
                end
            end
        end
    end

    task automatic expect_v(input string n, input int kind, input logic [15:0] v);
        exp_t e;
        e.name = n;
        e.kind = kind;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    // Hand queued expectations to the monitor at the next falling edge.
    task automatic sample();
        chk_valid = 1'b1;
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic drive(input logic [2:0] m, input logic [15:0] r, input logic [7:0] i);
        mode   = m;
        r_side = r;
        i_side = i;
    endtask

    task automatic commit(input logic [2:0] m, input logic [15:0] r, input logic [7:0] i,
                          input logic clr);
        drive(m, r, i);
        pc_en   = 1'b1;
        err_clr = clr;
        @(posedge clk);
        #1;
        pc_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ret_exp;

        // 1. Reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(MODE_PC1, 16'h0000, 8'h00);
        expect_v("rst_pc", K_PC, 16'h0100);
        expect_v("rst_sp", K_SP, 16'h0000);
        expect_v("rst_empty", K_EMPTY, 16'h0001);
        expect_v("rst_ovf", K_OVF, 16'h0000);
        expect_v("rst_unf", K_UNF, 16'h0000);
        expect_v("rst_addr_pc1", K_ADDR, 16'h0101);
        sample();

        // 2. PC1 increments and wrap
        commit(MODE_I0, 16'h0000, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) commit(MODE_PC1, 16'h0000, 8'h00, 1'b0);
        expect_v("pc1_x3", K_PC, 16'h0003);
        sample();
        commit(MODE_R0, 16'hFFFF, 8'h00, 1'b0);
        expect_v("r0_jump", K_PC, 16'hFFFF);
        sample();
        commit(MODE_PC1, 16'h0000, 8'h00, 1'b0);
        expect_v("pc1_wrap", K_PC, 16'h0000);
        sample();

        // 3. PC-relative with negative immediate, signed vs unsigned extension
        commit(MODE_I0, 16'h0000, 8'h10, 1'b0);
        drive(MODE_PCI, 16'h0000, 8'hF0);
        expect_v("pci_signed", K_ADDR, 16'h0000);
        expect_v("pci_unsigned", K_ADDRU, 16'h0100);
        sample();
        drive(MODE_I0, 16'h0000, 8'hF0);
        expect_v("i0_zext", K_ADDR, 16'h00F0);
        sample();

        // 4. CALLI / CALLR / RET / RET
        commit(MODE_I0, 16'h0000, 8'h20, 1'b0);
        commit(MODE_CALLI, 16'h0000, 8'h10, 1'b0);
        drive(MODE_RET, 16'h0000, 8'h00);
        expect_v("calli_pc", K_PC, 16'h0030);
        expect_v("calli_sp", K_SP, 16'h0001);
        expect_v("calli_top", K_ADDR, 16'h0021);
        sample();
        commit(MODE_CALLR, 16'h2000, 8'h00, 1'b0);
        expect_v("callr_pc", K_PC, 16'h2000);
        sample();
        commit(MODE_RET, 16'h0000, 8'h00, 1'b0);
        expect_v("ret1_pc", K_PC, 16'h0031);
        sample();
        commit(MODE_RET, 16'h0000, 8'h00, 1'b0);
        expect_v("ret2_pc", K_PC, 16'h0021);
        expect_v("ret2_empty", K_EMPTY, 16'h0001);
        sample();

        // 5. Overflow and underflow
        for (int k = 0; k < DEPTH; k++) commit(MODE_CALLR, 16'h1000 + 16'(k), 8'h00, 1'b0);
        drive(MODE_CALLR, 16'h5555, 8'h00);
        expect_v("fill_sp", K_SP, 16'h0008);
        expect_v("fill_full", K_FULL, 16'h0001);
        expect_v("full_call_addr", K_ADDR, 16'h1007);
        sample();
        commit(MODE_CALLR, 16'h5555, 8'h00, 1'b0);
        expect_v("ovf_pc", K_PC, 16'h1007);
        expect_v("ovf_flag", K_OVF, 16'h0001);
        expect_v("ovf_sp", K_SP, 16'h0008);
        sample();
        for (int k = 0; k < DEPTH; k++) begin
            commit(MODE_RET, 16'h0000, 8'h00, 1'b0);
            ret_exp = (k == DEPTH - 1) ? 16'h0022 : 16'h1007 - 16'(k);
            expect_v($sformatf("ret_chain_%0d", k), K_PC, ret_exp);
            sample();
        end
        drive(MODE_RET, 16'h0000, 8'h00);
        expect_v("empty_ret_addr", K_ADDR, 16'h0022);
        sample();
        commit(MODE_RET, 16'h0000, 8'h00, 1'b0);
        expect_v("unf_pc", K_PC, 16'h0022);
        expect_v("unf_flag", K_UNF, 16'h0001);
        expect_v("unf_sp", K_SP, 16'h0000);
        sample();
        commit(MODE_CALLR, 16'h3000, 8'h00, 1'b0);
        commit(MODE_RST_PC, 16'h0000, 8'h00, 1'b0);
        expect_v("rstpc_pc", K_PC, 16'h0100);
        expect_v("rstpc_sp", K_SP, 16'h0000);
        expect_v("rstpc_ovf_kept", K_OVF, 16'h0001);
        expect_v("rstpc_unf_kept", K_UNF, 16'h0001);
        sample();
        clear_errors();
        expect_v("clr_ovf", K_OVF, 16'h0000);
        expect_v("clr_unf", K_UNF, 16'h0000);
        sample();
        commit(MODE_RET, 16'h0000, 8'h00, 1'b1);
        expect_v("clr_vs_err_unf", K_UNF, 16'h0001);
        expect_v("clr_vs_err_ovf", K_OVF, 16'h0000);
        sample();
        clear_errors();

        // 6. Reset during a committed CALLI, then I0 address
        commit(MODE_I0, 16'h0000, 8'h40, 1'b0);
        commit(MODE_CALLI, 16'h0000, 8'h01, 1'b0);
        drive(MODE_CALLI, 16'h0000, 8'h05);
        pc_en = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        pc_en = 1'b0;
        rst   = 1'b0;
        drive(MODE_I0, 16'h0000, 8'h30);
        expect_v("midrst_pc", K_PC, 16'h0100);
        expect_v("midrst_sp", K_SP, 16'h0000);
        expect_v("midrst_empty", K_EMPTY, 16'h0001);
        expect_v("i0_addr", K_ADDR, 16'h0030);
        sample();

        n_assert++;
        if (address !== 16'h0030) begin
            n_fail++;
            $display("FAIL direct_i0_addr: got 0x%04h expected 0x0030", address);
        end else begin
            $display("ok   direct_i0_addr = 0x%04h", address);
        end
        n_assert++;
        if (address_u !== 16'h0030) begin
            n_fail++;
            $display("FAIL direct_i0_addr_u: got 0x%04h expected 0x0030", address_u);
        end else begin
            $display("ok   direct_i0_addr_u = 0x%04h", address_u);
        end
        n_assert++;
        if (pc !== 16'h0100) begin
            n_fail++;
            $display("FAIL direct_midrst_pc: got 0x%04h expected 0x0100", pc);
        end else begin
            $display("ok   direct_midrst_pc = 0x%04h", pc);
        end
        n_assert++;
        if (sp_count !== 4'd0) begin
            n_fail++;
            $display("FAIL direct_midrst_sp: got 0x%04h expected 0x0000", 16'(sp_count));
        end else begin
            $display("ok   direct_midrst_sp = 0x%04h", 16'(sp_count));
        end
        n_assert++;
        if (stack_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_midrst_empty: got %0b expected 1", stack_empty);
        end else begin
            $display("ok   direct_midrst_empty = %0b", stack_empty);
        end

        // Bounded drain of anything the monitor has not consumed
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) sample();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_assert++;
            n_fail++;
            $display("FAIL %s: never checked, expected 0x%04h", e.name, e.exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
